// File: rtl/scalar_mult_ctrl.sv
// Double-and-add command sequencer for Ed25519 scalar multiplication (MSB-first scan).
// Optional macro CONST_TIME_EN: insert DUMMY_ADD after every DBL on a clear bit.
module scalar_mult_ctrl #(
    parameter int N  = 255,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  n,
    input  logic [IW-1:0] msb_idx,
    output logic          op_valid,
    output logic [1:0]    op_code,
    input  logic          op_ready,
    input  logic          op_done,
    output logic [IW-1:0] bit_idx,
    output logic          busy,
    output logic          done,
    output logic          zero,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_DBL   = 2'b00,
        OP_ADD   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_DUMMY = 2'b11
    } op_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state_q;
    op_t           op_q;
    logic [N-1:0]  n_q;
    logic [IW-1:0] bit_idx_q;
    logic [IW-1:0] bit_idx_d;
    logic          op_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          zero_q;
    logic          err_q;
    logic          cur_bit;
    logic          msb_bad;

    // bit_idx_q doubles as the captured msb_idx until CHECK validates it.
    assign cur_bit   = n_q[bit_idx_q];
    assign msb_bad   = (bit_idx_q > LAST_IDX) || !cur_bit;
    assign bit_idx_d = bit_idx_q - IW'(1);

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_DBL;
            // NOTE: the scalar register is cleared too, so no key material survives a reset.
            n_q        <= '0;
            bit_idx_q  <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q       <= n;
                        bit_idx_q <= msb_idx;
                        busy_q    <= 1'b1;
                        zero_q    <= 1'b0;
                        state_q   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (n_q == '0) begin
                        zero_q  <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FINISH;
                    end else if (msb_bad) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        op_q       <= OP_LOAD;
                        op_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (op_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (op_q == OP_DBL && cur_bit) begin
                        op_q       <= OP_ADD;
                        op_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
`ifdef CONST_TIME_EN
                    end else if (op_q == OP_DBL) begin
                        op_q       <= OP_DUMMY;
                        op_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
`endif
                    end else if (bit_idx_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FINISH;
                    end else begin
                        bit_idx_q  <= bit_idx_d;
                        op_q       <= OP_DBL;
                        op_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign op_valid = op_valid_q;
    assign op_code  = op_q;
    assign bit_idx  = bit_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign zero     = zero_q;
    assign err      = err_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Self-checking bench for scalar_mult_ctrl: behavioural point-unit responder plus a
// per-bit reference model of the expected double-and-add command stream.
module tb_scalar_mult_ctrl;

    localparam int N  = 255;
    localparam int IW = 8;
    localparam logic [1:0] OP_DBL   = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_DUMMY = 2'b11;
`ifdef CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  n;
    logic [IW-1:0] msb_idx;
    logic          op_valid;
    logic [1:0]    op_code;
    logic          op_ready;
    logic          op_done;
    logic [IW-1:0] bit_idx;
    logic          busy;
    logic          done;
    logic          zero;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Point-unit model state, shared with the main sequence.
    logic [1:0]    log_code[$];
    logic [IW-1:0] log_bit[$];
    int            done_delay = 3;
    int            ready_low = 0;
    bit            rnd_ready = 1'b0;
    bit            stray_req = 1'b0;
    int            last_done_cyc = -1;
    int            dbl_cnt = 0;

    scalar_mult_ctrl #(.N(N), .IW(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n        (n),
        .msb_idx  (msb_idx),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_ready (op_ready),
        .op_done  (op_done),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .done     (done),
        .zero     (zero),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Point unit: logs each accepted command and answers with op_done after done_delay cycles.
    initial begin
        bit hs;
        int cnt;
        cnt      = 0;
        op_ready = 1'b1;
        op_done  = 1'b0;
        forever begin
            @(negedge clk);
            hs = op_valid && op_ready;
            if (hs) begin
                log_code.push_back(op_code);
                log_bit.push_back(bit_idx);
                if (op_code == OP_DBL) dbl_cnt++;
            end
            @(posedge clk);
            #1;
            op_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (hs) begin
                cnt = done_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    op_done       = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (stray_req) begin
                op_done   = 1'b1;
                stray_req = 1'b0;
            end
            if (ready_low > 0) begin
                op_ready = 1'b0;
                ready_low--;
            end else begin
                op_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic run(input string tag, input logic [N-1:0] nv, input logic [IW-1:0] mv,
                       input int stray_start_c, input bit stray_done_en);
        logic [1:0]    exp_code[$];
        logic [IW-1:0] exp_bit[$];
        bit            exp_zero;
        bit            exp_err;
        bit            ended;
        bit            prev_stall;
        logic [1:0]    prev_code;
        int            m;
        int            c;
        int            first_c;
        int            nops;

        // Reference: scan bits MSB-first; LOAD at the top bit, DBL per lower bit, ADD on set bits.
        m        = int'(mv);
        exp_zero = (nv == '0);
        exp_err  = !exp_zero && ((m >= N) || !nv[m]);
        if (!exp_zero && !exp_err) begin
            for (int i = m; i >= 0; i--) begin
                if (i == m) begin
                    exp_code.push_back(OP_LOAD);
                    exp_bit.push_back(IW'(i));
                end else begin
                    exp_code.push_back(OP_DBL);
                    exp_bit.push_back(IW'(i));
                    if (nv[i]) begin
                        exp_code.push_back(OP_ADD);
                        exp_bit.push_back(IW'(i));
                    end else if (CT) begin
                        exp_code.push_back(OP_DUMMY);
                        exp_bit.push_back(IW'(i));
                    end
                end
            end
        end

        log_code.delete();
        log_bit.delete();
        last_done_cyc = -1;
        @(posedge clk);
        #1;
        n       = nv;
        msb_idx = mv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        ended      = 1'b0;
        prev_stall = 1'b0;
        prev_code  = 2'b00;
        first_c    = -1;
        c          = 0;
        while (c < 20000) begin
            @(negedge clk);
            c++;
            if (c == 1) check({tag, " busy_after_start"}, busy, 1);
            if (op_valid && first_c < 0) first_c = c;
            if (prev_stall) begin
                check({tag, " hold_valid"}, op_valid, 1);
                check({tag, " hold_code"}, op_code, prev_code);
            end
            prev_stall = op_valid && !op_ready;
            prev_code  = op_code;
            if (c == stray_start_c) begin
                start   = 1'b1;
                n       = '0;
                msb_idx = '0;
            end else begin
                start = 1'b0;
            end
            if (stray_done_en && c == 3) stray_req = 1'b1;
            if (done || err) begin
                ended = 1'b1;
                break;
            end
        end
        start = 1'b0;

        check({tag, " ended"}, ended, 1);
        check({tag, " done"}, done, !exp_err);
        check({tag, " err"}, err, exp_err);
        check({tag, " zero"}, zero, exp_zero);
        check({tag, " busy_at_end"}, busy, 0);
        check({tag, " op_count"}, log_code.size(), exp_code.size());
        nops = (log_code.size() < exp_code.size()) ? log_code.size() : exp_code.size();
        for (int i = 0; i < nops; i++) begin
            check($sformatf("%s op%0d code", tag, i), log_code[i], exp_code[i]);
            check($sformatf("%s op%0d bit", tag, i), log_bit[i], exp_bit[i]);
        end
        if (exp_code.size() > 0) begin
            check({tag, " first_valid_latency"}, first_c, 2);
            check({tag, " done_after_last_op_done"}, cyc - last_done_cyc, 2);
        end else begin
            check({tag, " no_op_valid"}, first_c, -1);
            check({tag, " end_latency"}, c, 2);
        end

        @(negedge clk);
        check({tag, " done_pulse_one_cycle"}, done, 0);
        check({tag, " err_pulse_one_cycle"}, err, 0);
        check({tag, " zero_held"}, zero, exp_zero);
    endtask

    initial begin
        logic [N-1:0] big;
        logic [N-1:0] nv;
        int           m;
        bit           reached;

        rst_n   = 1'b1;
        start   = 1'b0;
        n       = '0;
        msb_idx = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset op_valid", op_valid, 0);
        check("reset op_code", op_code, 0);
        check("reset bit_idx", bit_idx, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset zero", zero, 0);
        check("reset err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single LOAD, 1011 pattern, zero scalar, inconsistent msb followed by a good start.
        done_delay = 3;
        run("t1_n1", N'(1), 8'd0, -1, 1'b0);
        run("t2_n11", N'(11), 8'd3, -1, 1'b0);
        run("t3_n0", N'(0), 8'd0, -1, 1'b0);
        run("t4_bad_msb", N'(4), 8'd1, -1, 1'b0);
        run("t4_after_err", N'(5), 8'd2, -1, 1'b0);
        run("t4_msb_oor", N'(7), 8'd255, -1, 1'b0);

        // Backpressure with a stray op_done during ISSUE and a stray start while busy.
        @(negedge clk);
        ready_low = 7;
        run("t5_backpressure", N'(13), 8'd3, 15, 1'b1);

        // Long scalar with reset asserted in the middle of the DBL chain.
        big      = '0;
        big[254] = 1'b1;
        big[0]   = 1'b1;
        done_delay = 1;
        dbl_cnt    = 0;
        @(posedge clk);
        #1;
        n       = big;
        msb_idx = 8'd254;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (dbl_cnt >= 100) begin
                reached = 1'b1;
                break;
            end
        end
        check("t6 reached_dbl100", reached, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst op_valid", op_valid, 0);
        check("t6 rst op_code", op_code, 0);
        check("t6 rst bit_idx", bit_idx, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst done", done, 0);
        check("t6 rst zero", zero, 0);
        check("t6 rst err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6 idle_busy", busy, 0);
        check("t6 idle_op_valid", op_valid, 0);
        run("t6_full", big, 8'd254, -1, 1'b0);

        // Randomised scalars, random ready and op_done latency.
        rnd_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            m  = $urandom_range(0, 40);
            nv = '0;
            for (int b = 0; b < m; b++) nv[b] = 1'($urandom_range(0, 1));
            nv[m] = (r != 3);
            done_delay = $urandom_range(1, 4);
            run($sformatf("rand%0d", r), nv, (r == 5) ? 8'd255 : IW'(m), -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
Double-and-add sequencer for Ed25519 scalar multiplication. It sits directly downstream of the scalar MSB priority encoder. It takes the scalar n and its MSB index, scans the bits from the MSB down to bit 0, and issues LOAD/DBL/ADD commands over a valid/ready + done handshake. The commands go to the extended-projective point arithmetic unit, which holds the base point produced by the affine-to-projective conversion stage.

Parameters:
N, 255, scalar width in bits
IW, $clog2(N) (=8), bit-index width; must match the priority encoder output width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
n  in  N  scalar; captured on accepted start
msb_idx  in  IW  index of highest set bit of n (priority encoder output); captured with n
op_valid  out  1  command valid toward point unit
op_code  out  2  00=DBL, 01=ADD, 10=LOAD (acc := base point), 11=DUMMY_ADD
op_ready  in  1  point unit accepts command when op_valid && op_ready
op_done  in  1  one-cycle pulse: point unit finished the accepted command
bit_idx  out  IW  index of the bit currently being processed
busy  out  1  high from accepted start until the cycle done/err pulses
done  out  1  one-cycle pulse: result valid in point unit accumulator
zero  out  1  valid with done; 1 = scalar was 0, so the result is the identity
err  out  1  one-cycle pulse: inconsistent msb_idx; no result

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; op_valid, op_code, bit_idx, busy, done, zero and err all = 0; the captured scalar register is cleared.
- States: IDLE, CHECK, ISSUE, WAIT, NEXT, FINISH.
- IDLE:
  - start=1 -> capture n and msb_idx, busy=1, go to CHECK.
  - start while busy is ignored; there is no queueing.
- CHECK (1 cycle):
  - n==0 -> FINISH with zero=1; no commands are issued.
  - msb_idx>=N or n[msb_idx]==0 -> err pulse, busy=0, return to IDLE.
  - Otherwise bit_idx=msb_idx, pending op=LOAD, go to ISSUE.
- ISSUE:
  - op_valid=1; op_code is held stable until op_valid&&op_ready.
  - Handshake cycle -> op_valid=0 next cycle, go to WAIT.
- WAIT:
  - Hold until op_done=1.
  - op_done in any other state is ignored.
  - op_done in the same cycle as the handshake is not allowed (the point unit is multi-cycle); it is ignored.
- NEXT, selecting the next op after each op_done:
  - After LOAD, or after ADD/DUMMY_ADD: if bit_idx==0 -> FINISH. Otherwise bit_idx-=1, op=DBL, go to ISSUE.
  - After DBL: if n[bit_idx]==1 -> op=ADD, go to ISSUE. Otherwise -> same rule as after ADD (continue, or FINISH at bit 0).
  - bit_idx never wraps below 0.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- zero:
  - Driven with done; 1 only for the n==0 case.
  - Holds its value until the next accepted start.
- Command count for msb=m: 1 LOAD + m DBL + (popcount(n)-1) ADD.
- Latency:
  - start -> first op_valid = 2 cycles (CHECK, then ISSUE).
  - Last op_done -> done = 2 cycles (NEXT, then FINISH).
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The point unit state is undefined; software restarts with start.
- start and done in the same cycle: start is not accepted, because the FSM is not yet in IDLE.

Optional Feature:
CONST_TIME_EN:
- Defined: after every DBL whose bit is 0, the block issues DUMMY_ADD (op_code 11). The point unit performs the add and discards the result, so for a given msb the command stream does not depend on the scalar bits. Command count = 1 + 2m.
- Undefined: no DUMMY_ADD is ever emitted; behaviour is as above.

Test Plan:
1. n=1, msb_idx=0, op_ready=1, op_done 3 cycles after each accept -> exactly one LOAD; done=1, zero=0; busy low after done.
2. n=11 (0b1011), msb_idx=3:
   - Without the macro -> op_codes LOAD, DBL, DBL, ADD, DBL, ADD; bit_idx 3, 2, 1, 1, 0, 0; then done.
   - With CONST_TIME_EN -> LOAD, DBL, DUMMY, DBL, ADD, DBL, ADD.
3. n=0, msb_idx=0 -> no op_valid; done pulse 2 cycles after start with zero=1.
4. n=4, msb_idx=1 (bit 1 clear) -> err pulse, no op_valid, busy=0; a subsequent valid start is processed normally.
5. Backpressure and stray inputs:
   - op_ready low for 5 cycles -> op_valid and op_code held stable; one accept only.
   - Stray op_done during ISSUE -> ignored.
   - start during busy -> ignored.
6. n=2^254+1, msb_idx=254 -> 254 DBL and 1 ADD (the final ADD follows DBL at bit 0). Assert rst_n mid-run at DBL #100 -> all outputs 0 asynchronously; IDLE after release.
